cpu_clk_ctrl: RTL and testbench

Parametrised clock controller for the multicycle CPU. It derives a gated CPU clock and a matching single-cycle enable strobe from the board clock, and supports four modes: halt, free run at a programmable rate, single step from a debounced push-button, and N-cycle burst. It sits between the board clock/buttons and the CPU top level. It replaces the fixed-rate run/step selector with a glitch-free registered output and a CPU-driven halt.

---
 rtl/clkc_pkg.sv | 15 +
 rtl/btn_debounce.sv | 57 +++++
 rtl/cpu_clk_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkc_pkg.sv
// Shared definitions for the CPU clock controller: mode encodings and FSM states.
package clkc_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        // Counter only advances while the synchronised input disagrees with the
        // accepted level; any agreeing sample restarts the stability window.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: derives a registered, glitch-free gated CPU clock and
// enable strobe in HALT / RUN / STEP / BURST modes.
module cpu_clk_ctrl
    import clkc_pkg::*;
#(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned BURST_W    = 8
) (
    input  logic               clk100m,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   div,
    input  logic               step,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt_req,
    output logic               cpu_clk,
    output logic               cpu_en,
    output logic               busy,
    output logic               halted,
    output logic [31:0]        cycle_cnt
);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   phase_q,     phase_d;
    logic [CNT_W-1:0]   div_q,       div_d;
    logic [BURST_W-1:0] rem_q,       rem_d;
    logic               halted_q,    halted_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;
    logic               cpu_clk_q,   cpu_clk_d;
    logic               cpu_en_q,    cpu_en_d;

    logic step_pulse;
    logic run_ok;
    logic start;
    logic phase_end;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_deb (
        .clk  (clk100m),
        .rst  (rst),
        .btn  (step),
        .pulse(step_pulse)
    );

    assign run_ok    = (mode == MODE_RUN) && !halted_q;
    assign phase_end = (phase_q == div_q);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        div_d       = div_q;
        rem_d       = rem_q;
        cycle_cnt_d = cycle_cnt_q;
        start       = 1'b0;

        if (mode == MODE_HALT) begin
            halted_d = 1'b0;
        end else if (halt_req) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end

        case (state_q)
            S_IDLE: begin
                if (run_ok) begin
                    start = 1'b1;
                end else if (step_pulse && (mode == MODE_STEP)) begin
                    start = 1'b1;
                end else if (step_pulse && (mode == MODE_BURST) && (burst_len != '0)) begin
                    start = 1'b1;
                    rem_d = burst_len - BURST_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    state_d = S_LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                // Mode is only consulted here, so a period in flight always completes.
                if (phase_end) begin
                    if (run_ok) begin
                        start = 1'b1;
                    end else if ((mode == MODE_BURST) && (rem_q != '0)) begin
                        start = 1'b1;
                        rem_d = rem_q - BURST_W'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d     = S_HIGH;
            phase_d     = '0;
            div_d       = div;
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end

        cpu_clk_d = (state_d == S_HIGH);
        cpu_en_d  = start;
    end

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            cpu_clk_q   <= 1'b0;
            cpu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            cpu_clk_q   <= cpu_clk_d;
            cpu_en_q    <= cpu_en_d;
        end
    end

    assign cpu_clk   = cpu_clk_q;
    assign cpu_en    = cpu_en_q;
    assign busy      = (state_q != S_IDLE);
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: period-position reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cpu_clk_ctrl;

    localparam int unsigned CNT_W = 27;
    localparam int unsigned DEB   = 16;
    localparam int unsigned BW    = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic [CNT_W-1:0] div;
    logic             step;
    logic [BW-1:0]    burst_len;
    logic             halt_req;
    logic             cpu_clk;
    logic             cpu_en;
    logic             busy;
    logic             halted;
    logic [31:0]      cycle_cnt;

    int checks = 0;
    int errors = 0;

    cpu_clk_ctrl #(
        .CNT_W     (CNT_W),
        .DEB_CYCLES(DEB),
        .BURST_W   (BW)
    ) dut (
        .clk100m  (clk),
        .rst      (rst),
        .mode     (mode),
        .div      (div),
        .step     (step),
        .burst_len(burst_len),
        .halt_req (halt_req),
        .cpu_clk  (cpu_clk),
        .cpu_en   (cpu_en),
        .busy     (busy),
        .halted   (halted),
        .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a period is 2*len cycles, the clock is high for the first len.
    bit          m_active;
    int          m_pos;
    int          m_len;
    int          m_bl;
    bit          m_halted;
    bit   [31:0] m_cnt;
    bit          m_en;
    bit          m_level;
    bit          m_pulse;
    bit          rh1, rh2;
    bit          win[$];

    always @(posedge clk or posedge rst) begin
        bit x, pulse_now, all_new, start, run_ok;
        if (rst) begin
            m_active = 0; m_pos = 0; m_len = 1; m_bl = 0; m_halted = 0;
            m_cnt = 0; m_en = 0; m_level = 0; m_pulse = 0; rh1 = 0; rh2 = 0;
            win.delete();
        end else begin
            pulse_now = m_pulse;
            x = rh2; rh2 = rh1; rh1 = step;
            win.push_back(x);
            if (win.size() > DEB) void'(win.pop_front());
            m_pulse = 0;
            if (win.size() == DEB) begin
                all_new = 1;
                foreach (win[i]) if (win[i] == m_level) all_new = 0;
                if (all_new) begin
                    m_level = x;
                    m_pulse = x;
                end
            end
            start  = 0;
            run_ok = (mode == 2'b01) && !m_halted;
            if (m_active) begin
                if (m_pos < 2 * m_len - 1) m_pos++;
                else if (run_ok) start = 1;
                else if (mode == 2'b11 && m_bl != 0) begin m_bl--; start = 1; end
                else m_active = 0;
            end else begin
                if (run_ok) start = 1;
                else if (pulse_now && mode == 2'b10) start = 1;
                else if (pulse_now && mode == 2'b11 && burst_len != 0) begin
                    start = 1;
                    m_bl = int'(burst_len) - 1;
                end
            end
            if (start) begin
                m_active = 1; m_pos = 0; m_len = int'(div) + 1; m_cnt++;
            end
            m_en = start;
            if (mode == 2'b00) m_halted = 0;
            else if (halt_req) m_halted = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_cpu_clk", {31'd0, cpu_clk}, {31'd0, (m_active && m_pos < m_len)});
            chk("model_cpu_en",  {31'd0, cpu_en},  {31'd0, m_en});
            chk("model_busy",    {31'd0, busy},    {31'd0, m_active});
            chk("model_halted",  {31'd0, halted},  {31'd0, m_halted});
            chk("model_cycle_cnt", cycle_cnt, m_cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n_en, n_hi, n_lo, n_busy;
        rst = 1; mode = 2'b00; div = '0; step = 0; burst_len = '0; halt_req = 0;
        cyc(3);
        chk("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
        chk("rst_cpu_en",  {31'd0, cpu_en},  32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_halted",  {31'd0, halted},  32'd0);
        chk("rst_cnt",     cycle_cnt,        32'd0);
        #1 rst = 0;
        cyc(2);

        // RUN, div=4: 10-cycle period, 10 pulses in 100 cycles
        div = 27'd4; mode = 2'b01;
        n_en = 0; n_hi = 0;
        repeat (100) begin
            @(negedge clk);
            n_en += int'(cpu_en);
            n_hi += int'(cpu_clk);
        end
        chk("run_cnt_100", cycle_cnt, 32'd10);
        chk("run_en_100", n_en, 10);
        chk("run_high_100", n_hi, 50);
        mode = 2'b00;
        wait_idle("run_stop_idle", 20);

        // halt_req mid-HIGH in RUN
        mode = 2'b01;
        for (int i = 0; i < 20 && !(cpu_clk && !cpu_en); i++) @(negedge clk);
        chk("halt_mid_high", {31'd0, cpu_clk}, 32'd1);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        chk("halt_latched", {31'd0, halted}, 32'd1);
        n_en = 0;
        repeat (20) begin @(negedge clk); n_en += int'(cpu_en); end
        chk("halt_no_en", n_en, 0);
        chk("halt_idle", {31'd0, busy}, 32'd0);
        chk("halt_still", {31'd0, halted}, 32'd1);
        mode = 2'b00;
        @(negedge clk);
        chk("halt_cleared", {31'd0, halted}, 32'd0);
        mode = 2'b01;
        @(negedge clk);
        chk("run_restart_en", {31'd0, cpu_en}, 32'd1);
        mode = 2'b00;
        wait_idle("restart_idle", 20);

        // STEP with bounce; second press while busy discarded
        mode = 2'b10; div = 27'd40;
        n_en = 0;
        for (int i = 0; i < 10; i++) begin step = ~step; @(negedge clk); n_en += int'(cpu_en); end
        step = 1;
        for (int i = 0; i < 60 && !busy; i++) begin @(negedge clk); n_en += int'(cpu_en); end
        chk("step_started", {31'd0, busy}, 32'd1);
        step = 0;
        repeat (20) begin @(negedge clk); n_en += int'(cpu_en); end
        step = 1;
        repeat (25) begin @(negedge clk); n_en += int'(cpu_en); end
        step = 0;
        for (int i = 0; i < 200 && busy; i++) begin @(negedge clk); n_en += int'(cpu_en); end
        repeat (25) begin @(negedge clk); n_en += int'(cpu_en); end
        chk("step_one_en", n_en, 1);
        chk("step_idle", {31'd0, busy}, 32'd0);

        // BURST, len=3, div=1: 3 periods, 12 busy cycles
        mode = 2'b11; div = 27'd1; burst_len = 8'd3;
        n_en = 0; n_busy = 0;
        step = 1;
        repeat (60) begin @(negedge clk); n_en += int'(cpu_en); n_busy += int'(busy); end
        step = 0;
        repeat (30) begin @(negedge clk); n_en += int'(cpu_en); n_busy += int'(busy); end
        chk("burst_en3", n_en, 3);
        chk("burst_busy12", n_busy, 12);
        burst_len = 8'd0;
        n_en = 0;
        step = 1;
        repeat (30) begin @(negedge clk); n_en += int'(cpu_en); end
        step = 0;
        repeat (30) begin @(negedge clk); n_en += int'(cpu_en); end
        chk("burst_len0_none", n_en, 0);

        // RUN->STEP and div change mid-HIGH keep the old period length
        mode = 2'b01; div = 27'd5;
        for (int i = 0; i < 20 && !cpu_en; i++) @(negedge clk);
        chk("chg_started", {31'd0, cpu_en}, 32'd1);
        mode = 2'b10; div = 27'd1;
        n_hi = 1;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (!cpu_clk) break; n_hi++; end
        n_lo = 1;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (!busy) break; n_lo++; end
        chk("chg_high6", n_hi, 6);
        chk("chg_low6", n_lo, 6);
        chk("chg_idle", {31'd0, busy}, 32'd0);
        cyc(5);

        // asynchronous reset mid-HIGH
        mode = 2'b01; div = 27'd3;
        for (int i = 0; i < 20 && !cpu_en; i++) @(negedge clk);
        @(negedge clk);
        chk("rst_mid_high", {31'd0, cpu_clk}, 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
        chk("arst_cpu_en",  {31'd0, cpu_en},  32'd0);
        chk("arst_busy",    {31'd0, busy},    32'd0);
        chk("arst_cnt",     cycle_cnt,        32'd0);
        mode = 2'b00;
        cyc(2);
        #1 rst = 0;
        cyc(2);

        // div=0: 2-cycle period
        mode = 2'b01; div = 27'd0;
        n_en = 0; n_hi = 0;
        repeat (10) begin @(negedge clk); n_en += int'(cpu_en); n_hi += int'(cpu_clk); end
        chk("div0_en5", n_en, 5);
        chk("div0_high5", n_hi, 5);
        mode = 2'b00;
        wait_idle("div0_idle", 10);

        // cycle_cnt wraps from all-ones to zero
        @(negedge clk);
        #2;
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        #2;
        release dut.cycle_cnt_q;
        @(negedge clk);
        chk("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
        mode = 2'b10;
        n_en = 0;
        step = 1;
        repeat (25) begin @(negedge clk); n_en += int'(cpu_en); end
        step = 0;
        repeat (25) begin @(negedge clk); n_en += int'(cpu_en); end
        chk("wrap_en1", n_en, 1);
        chk("wrap_zero", cycle_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
